// File: rtl/msk_hpc3_pkg.sv
// Shared constants for the HPC3 masked-AND feeder: share count defaults and
// the per-issue randomness width derived from the number of shares.
package msk_hpc3_pkg;

    localparam int D_DEFAULT          = 2;
    localparam int SHIDX_BITS_DEFAULT = 3;

    // HPC3 consumes d*(d-1) fresh random bits for every gadget issue.
    function automatic int rnd_width(input int d);
        return d * (d - 1);
    endfunction

endpackage

// File: rtl/msk_hpc3_feeder_if.sv
// Bundle of every stream and gadget signal around the feeder; the slave
// modport is the feeder's view, master is the environment's view.
interface msk_hpc3_feeder_if
    import msk_hpc3_pkg::*;
#(
    parameter int d          = D_DEFAULT,
    parameter int SHIDX_BITS = SHIDX_BITS_DEFAULT
) ();

    localparam int RND_W = rnd_width(d);

    logic                  in_valid;
    logic                  in_ready;
    logic [d-1:0]          in_a;
    logic [d-1:0]          in_b;
    logic                  rnd_valid;
    logic                  rnd_ready;
    logic [RND_W-1:0]      rnd_in;
    logic [SHIDX_BITS-1:0] cfg_s;
    logic [d-1:0]          g_ina;
    logic [d-1:0]          g_inb;
    logic [RND_W-1:0]      g_rnd;
    logic [d-1:0]          g_ina_prev;
    logic [SHIDX_BITS-1:0] g_s;
    logic [d-1:0]          g_out;
    logic                  out_valid;
    logic                  out_ready;
    logic [d-1:0]          out_data;

    modport master (
        output in_valid, in_a, in_b, rnd_valid, rnd_in, cfg_s, g_out, out_ready,
        input  in_ready, rnd_ready, g_ina, g_inb, g_rnd, g_ina_prev, g_s,
               out_valid, out_data
    );

    modport slave (
        input  in_valid, in_a, in_b, rnd_valid, rnd_in, cfg_s, g_out, out_ready,
        output in_ready, rnd_ready, g_ina, g_inb, g_rnd, g_ina_prev, g_s,
               out_valid, out_data
    );

endinterface

// File: rtl/msk_share_fifo2.sv
// Two-entry share FIFO; head reads as zero whenever the FIFO is empty so no
// stale share ever leaves the block.
module msk_share_fifo2 #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [1:0]   count,
    output logic [W-1:0] head
);

    logic [W-1:0] mem [2];
    logic         rd_ptr;
    logic         wr_ptr;
    logic         do_push;
    logic         do_pop;

    // A push into a full FIFO is accepted only if the head leaves in the same cycle.
    assign do_pop  = pop && (count != 2'd0);
    assign do_push = push && ((count != 2'd2) || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head = (count != 2'd0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/msk_hpc3_feeder.sv
// Feeds an external HPC3 masked-AND gadget from paired operand/randomness
// streams and buffers its one-cycle-late result in a two-entry FIFO.
module msk_hpc3_feeder
    import msk_hpc3_pkg::*;
#(
    parameter int d          = D_DEFAULT,
    parameter int SHIDX_BITS = SHIDX_BITS_DEFAULT
) (
    input logic               clk,
    input logic               rst,
    msk_hpc3_feeder_if.slave  bus
);

    localparam int RND_W = rnd_width(d);

    logic [1:0]            fifo_count;
    logic [d-1:0]          fifo_head;
    logic                  inflight;
    logic [d-1:0]          prev_a;
    logic [SHIDX_BITS-1:0] prev_s;
    logic                  out_valid_int;
    logic                  pop;
    logic                  push;
    logic [2:0]            committed;
    logic                  credit;
    logic                  issue;

    assign out_valid_int = !rst && (fifo_count != 2'd0);
    assign pop           = out_valid_int && bus.out_ready;
    assign push          = !rst && inflight;

    // The slot freed by this cycle's pop is counted, so a drained-every-cycle
    // FIFO still grants credit and one issue per cycle is sustained.
    assign committed = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
    assign credit    = (committed < 3'd2);
    assign issue     = !rst && bus.in_valid && bus.rnd_valid && credit;

    assign bus.in_ready  = issue;
    assign bus.rnd_ready = issue;

    assign bus.g_ina = issue ? bus.in_a   : '0;
    assign bus.g_inb = issue ? bus.in_b   : '0;
    assign bus.g_rnd = issue ? bus.rnd_in : {RND_W{1'b0}};

    assign bus.g_ina_prev = push ? prev_a : '0;
    assign bus.g_s        = push ? prev_s : '0;

    // Latency-1 gadget operands are captured at issue and live for exactly one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= 1'b0;
            prev_a   <= '0;
            prev_s   <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                prev_a <= bus.in_a;
                prev_s <= bus.cfg_s;
            end
        end
    end

    msk_share_fifo2 #(
        .W (d)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (bus.g_out),
        .pop       (pop),
        .count     (fifo_count),
        .head      (fifo_head)
    );

    assign bus.out_valid = out_valid_int;
    assign bus.out_data  = out_valid_int ? fifo_head : '0;

endmodule

// File: tb/tb_msk_hpc3_feeder.sv
// Self-checking bench for msk_hpc3_feeder (d=2): directed scenarios with literal
// expectations plus a randomized run against a queue-based reference model.
module tb_msk_hpc3_feeder;

    logic clk = 1'b0;
    logic rst;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [1:0] a;
        logic [2:0] s;
    } pend_t;

    logic [1:0] exp_q[$];
    pend_t      pend_q[$];

    msk_hpc3_feeder_if #(.d(2), .SHIDX_BITS(3)) bus ();

    msk_hpc3_feeder #(.d(2), .SHIDX_BITS(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic compareValue(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    // Inputs change 2 time units after the rising edge and hold for the whole cycle.
    task automatic applyStimulus(input logic iv, input logic rv, input logic [1:0] a,
                                 input logic [1:0] b, input logic [1:0] r, input logic [2:0] s,
                                 input logic ordy, input logic [1:0] gout, input logic rs);
        @(posedge clk);
        #2;
        bus.in_valid  = iv;
        bus.rnd_valid = rv;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.rnd_in    = r;
        bus.cfg_s     = s;
        bus.out_ready = ordy;
        bus.g_out     = gout;
        rst           = rs;
    endtask

    task automatic idleCycle(input logic [1:0] gout);
        applyStimulus(1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 1'b1, gout, 1'b0);
    endtask

    // Reference: results waiting for the consumer form a queue of at most two,
    // an accepted pair occupies a slot from issue until it is consumed.
    task automatic checkOutput();
        bit         e_ov;
        bit         pop;
        bit         e_issue;
        int         room;
        logic [1:0] e_prev;
        logic [2:0] e_s;
        if (rst) begin
            compareValue("rst_out_valid",  bus.out_valid,  0);
            compareValue("rst_in_ready",   bus.in_ready,   0);
            compareValue("rst_rnd_ready",  bus.rnd_ready,  0);
            compareValue("rst_g_ina",      bus.g_ina,      0);
            compareValue("rst_g_inb",      bus.g_inb,      0);
            compareValue("rst_g_rnd",      bus.g_rnd,      0);
            compareValue("rst_g_ina_prev", bus.g_ina_prev, 0);
            compareValue("rst_g_s",        bus.g_s,        0);
            exp_q.delete();
            pend_q.delete();
        end else begin
            e_ov    = exp_q.size() > 0;
            pop     = e_ov && bus.out_ready;
            room    = 2 - exp_q.size() - pend_q.size() + (pop ? 1 : 0);
            e_issue = bus.in_valid && bus.rnd_valid && (room > 0);
            e_prev  = (pend_q.size() > 0) ? pend_q[0].a : 2'b00;
            e_s     = (pend_q.size() > 0) ? pend_q[0].s : 3'b000;
            compareValue("out_valid",  bus.out_valid,  32'(e_ov));
            compareValue("out_data",   bus.out_data,   e_ov ? 32'(exp_q[0]) : 0);
            compareValue("in_ready",   bus.in_ready,   32'(e_issue));
            compareValue("rnd_ready",  bus.rnd_ready,  32'(e_issue));
            compareValue("g_ina",      bus.g_ina,      e_issue ? 32'(bus.in_a) : 0);
            compareValue("g_inb",      bus.g_inb,      e_issue ? 32'(bus.in_b) : 0);
            compareValue("g_rnd",      bus.g_rnd,      e_issue ? 32'(bus.rnd_in) : 0);
            compareValue("g_ina_prev", bus.g_ina_prev, 32'(e_prev));
            compareValue("g_s",        bus.g_s,        32'(e_s));
            if (pop) void'(exp_q.pop_front());
            if (pend_q.size() > 0) begin
                exp_q.push_back(bus.g_out);
                void'(pend_q.pop_front());
            end
            if (e_issue) pend_q.push_back({bus.in_a, bus.cfg_s});
            compareValue("model_occupancy", 32'(exp_q.size() + pend_q.size() <= 2), 1);
        end
    endtask

    always @(negedge clk) checkOutput();

    initial begin
        int issues;
        int pops;
        rst           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.rnd_valid = 1'b1;
        bus.in_a      = 2'b11;
        bus.in_b      = 2'b11;
        bus.rnd_in    = 2'b11;
        bus.cfg_s     = 3'b111;
        bus.out_ready = 1'b1;
        bus.g_out     = 2'b11;

        // Reset holds every output low even with both streams valid.
        applyStimulus(1'b1, 1'b1, 2'b11, 2'b11, 2'b11, 3'b111, 1'b1, 2'b11, 1'b1);
        @(negedge clk);
        compareValue("reset_in_ready", bus.in_ready, 0);
        compareValue("reset_out_valid", bus.out_valid, 0);
        compareValue("reset_g_ina", bus.g_ina, 0);

        // Single transfer with literal expectations.
        applyStimulus(1'b1, 1'b1, 2'b01, 2'b11, 2'b10, 3'b001, 1'b1, 2'b00, 1'b0);
        @(negedge clk);
        compareValue("single_t0_in_ready", bus.in_ready, 1);
        compareValue("single_t0_rnd_ready", bus.rnd_ready, 1);
        compareValue("single_t0_g_ina", bus.g_ina, 2'b01);
        compareValue("single_t0_g_inb", bus.g_inb, 2'b11);
        compareValue("single_t0_g_rnd", bus.g_rnd, 2'b10);
        compareValue("single_t0_out_valid", bus.out_valid, 0);
        idleCycle(2'b10);
        @(negedge clk);
        compareValue("single_t1_g_ina_prev", bus.g_ina_prev, 2'b01);
        compareValue("single_t1_g_s", bus.g_s, 3'b001);
        compareValue("single_t1_out_valid", bus.out_valid, 0);
        idleCycle(2'b00);
        @(negedge clk);
        compareValue("single_t2_out_valid", bus.out_valid, 1);
        compareValue("single_t2_out_data", bus.out_data, 2'b10);
        idleCycle(2'b00);
        @(negedge clk);
        compareValue("single_t3_out_valid", bus.out_valid, 0);
        compareValue("single_t3_g_ina_prev", bus.g_ina_prev, 0);

        // Streaming: eight back-to-back issues, eight outputs.
        pops = 0;
        for (int i = 0; i < 11; i++) begin
            applyStimulus(i < 8, i < 8, 2'(i), 2'(~i), 2'(i + 1), 3'(i), 1'b1, 2'(i * 3), 1'b0);
            @(negedge clk);
            if (i < 8) compareValue("stream_in_ready", bus.in_ready, 1);
            if (bus.out_valid) pops++;
        end
        compareValue("stream_pops", pops, 8);

        // Backpressure: only two issues fit, then everything drains.
        issues = 0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 1'b1, 2'($urandom), 2'($urandom), 2'($urandom), 3'($urandom),
                          1'b0, 2'($urandom), 1'b0);
            @(negedge clk);
            if (bus.in_ready) issues++;
        end
        compareValue("bp_issues", issues, 2);
        pops = 0;
        for (int i = 0; i < 4; i++) begin
            idleCycle(2'($urandom));
            @(negedge clk);
            if (bus.out_valid) pops++;
        end
        compareValue("bp_drain_pops", pops, 2);

        // Randomness starvation stalls issue and keeps gadget inputs quiet.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b0, 2'b11, 2'b10, 2'b01, 3'b101, 1'b1, 2'b00, 1'b0);
            @(negedge clk);
            compareValue("starve_in_ready", bus.in_ready, 0);
            compareValue("starve_rnd_ready", bus.rnd_ready, 0);
            compareValue("starve_g_ina", bus.g_ina, 0);
            compareValue("starve_g_rnd", bus.g_rnd, 0);
        end
        applyStimulus(1'b1, 1'b1, 2'b11, 2'b10, 2'b01, 3'b101, 1'b1, 2'b00, 1'b0);
        @(negedge clk);
        compareValue("starve_resume_in_ready", bus.in_ready, 1);
        for (int i = 0; i < 3; i++) idleCycle(2'($urandom));

        // Reset one cycle after an issue discards the gadget result.
        applyStimulus(1'b1, 1'b1, 2'b10, 2'b01, 2'b11, 3'b010, 1'b1, 2'b00, 1'b0);
        applyStimulus(1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 1'b1, 2'b11, 1'b1);
        @(negedge clk);
        compareValue("midrst_g_ina_prev", bus.g_ina_prev, 0);
        for (int i = 0; i < 3; i++) begin
            idleCycle(2'b11);
            @(negedge clk);
            compareValue("midrst_out_valid", bus.out_valid, 0);
        end
        applyStimulus(1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 1'b1, 2'b00, 1'b1);
        applyStimulus(1'b1, 1'b1, 2'b10, 2'b10, 2'b01, 3'b100, 1'b1, 2'b00, 1'b0);
        @(negedge clk);
        compareValue("postrst_in_ready", bus.in_ready, 1);
        idleCycle(2'b11);
        @(negedge clk);
        compareValue("postrst_t1_out_valid", bus.out_valid, 0);
        compareValue("postrst_t1_g_s", bus.g_s, 3'b100);
        idleCycle(2'b00);
        @(negedge clk);
        compareValue("postrst_t2_out_valid", bus.out_valid, 1);
        compareValue("postrst_t2_out_data", bus.out_data, 2'b11);

        // Push and pop together at one stored entry keep order.
        applyStimulus(1'b1, 1'b1, 2'b01, 2'b01, 2'b01, 3'b011, 1'b1, 2'b00, 1'b0);
        applyStimulus(1'b1, 1'b1, 2'b10, 2'b10, 2'b10, 3'b110, 1'b1, 2'b01, 1'b0);
        @(negedge clk);
        compareValue("pp_second_issue", bus.in_ready, 1);
        idleCycle(2'b10);
        @(negedge clk);
        compareValue("pp_first_out_valid", bus.out_valid, 1);
        compareValue("pp_first_out_data", bus.out_data, 2'b01);
        idleCycle(2'b00);
        @(negedge clk);
        compareValue("pp_second_out_valid", bus.out_valid, 1);
        compareValue("pp_second_out_data", bus.out_data, 2'b10);
        idleCycle(2'b00);
        @(negedge clk);
        compareValue("pp_empty_out_valid", bus.out_valid, 0);

        // Randomized traffic with occasional resets, checked by the model.
        for (int i = 0; i < 1500; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                          2'($urandom), 2'($urandom), 2'($urandom), 3'($urandom),
                          $urandom_range(0, 2) != 0, 2'($urandom),
                          $urandom_range(0, 63) == 0);
        end
        for (int i = 0; i < 4; i++) idleCycle(2'($urandom));
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
